// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
//   Groups the write/read handshake and status signals of sync_fifo_param.
//   clk and rst are not part of this bundle; they are plain module ports.
//
//   Parameters: DATA_W (word width), ADDR_W (address width, DEPTH = 2**ADDR_W)
//   Signals:
//     wr_en, wr_data      write request and data        (master -> slave)
//     rd_en               read request / FWFT acknowledge (master -> slave)
//     rd_data, rd_valid   registered read data and valid (slave -> master)
//     full, empty, almost_full, almost_empty, count       (slave -> master)
//     overflow, underflow sticky error flags              (slave -> master)
//   Modports: master (producer/consumer side), slave (the FIFO).
// -----------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) ();
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO with full-depth usage, fill count,
//   programmable almost-full/almost-empty thresholds and sticky
//   overflow/underflow flags. Every output is registered.
//
//   Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through mode.
//   In that mode the output register is refilled from RAM automatically,
//   empty = ~rd_valid, rd_en pops the shown word and count includes the
//   output register. Without the macro the FIFO is a standard 1-cycle-latency
//   read FIFO.
//
//   Ports:
//     clk  single clock, rising edge
//     rst  synchronous active-high reset
//     bus  sync_fifo_param_if.slave (write/read handshake and status)
// -----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 11,
    parameter int AFULL_THRESH  = 2040,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic                clk,
    input  logic                rst,
    sync_fifo_param_if.slave    bus
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] ZERO_C   = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              aempty_q, aempty_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              wr_accept_s;  // word enters RAM this edge
    logic              pop_s;        // consumer takes a word this edge
    logic              rd_load_s;    // RAM head moves into rd_data this edge

`ifdef SYNC_FIFO_FWFT_EN
    // Set when RAM held a word already written on an earlier edge; this delay
    // places the first word on rd_data two edges after its write edge.
    logic              ram_avail_q, ram_avail_d;
`endif

    // Next-state logic for pointers, count, read register and flags.
    always_comb begin
        wr_accept_s = bus.wr_en & ~full_q;
`ifdef SYNC_FIFO_FWFT_EN
        pop_s       = bus.rd_en & rd_valid_q;
        // Refill the output register whenever it is empty or being popped.
        rd_load_s   = ram_avail_q & (~rd_valid_q | pop_s);
`else
        pop_s       = bus.rd_en & ~empty_q;
        rd_load_s   = pop_s;
`endif

        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_load_s) begin
            rd_ptr_d  = rd_ptr_q + ONE_C;
            rd_data_d = mem[rd_ptr_q[ADDR_W-1:0]];
        end else begin
            rd_ptr_d  = rd_ptr_q;
            rd_data_d = rd_data_q;
        end

        // A refill only moves a word inside the FIFO, so count follows
        // accepted writes and pops alone.
        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

`ifdef SYNC_FIFO_FWFT_EN
        rd_valid_d  = rd_load_s | (rd_valid_q & ~pop_s);
        empty_d     = ~rd_valid_d;
        full_d      = (count_d == DEPTH_C);
        ram_avail_d = (wr_ptr_q != rd_ptr_d);
`else
        rd_valid_d  = rd_load_s;
        empty_d     = (wr_ptr_d == rd_ptr_d);
        // Same address with different wrap bit means the writer lapped the reader.
        full_d      = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                      (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
`endif

        afull_d     = (count_d >= AFULL_C);
        aempty_d    = (count_d <= AEMPTY_C);
        overflow_d  = overflow_q  | (bus.wr_en & full_q);
        underflow_d = underflow_q | (bus.rd_en & empty_q);
    end

    // Storage array write port; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= ZERO_C;
            rd_ptr_q    <= ZERO_C;
            count_q     <= ZERO_C;
            rd_data_q   <= {DATA_W{1'b0}};
            rd_valid_q  <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
            ram_avail_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
`ifdef SYNC_FIFO_FWFT_EN
            ram_avail_q <= ram_avail_d;
`endif
        end
    end

    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
//   Directed self-checking bench for sync_fifo_param (DATA_W=8, ADDR_W=11).
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, after the registers have settled.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sync_fifo_param_if #(.DATA_W(8), .ADDR_W(11)) bus ();

    sync_fifo_param #(
        .DATA_W(8), .ADDR_W(11), .AFULL_THRESH(2040), .AEMPTY_THRESH(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs held across the rising edge.
    task automatic step(input logic wr, input logic [7:0] d, input logic rd);
        bus.wr_en   = wr;
        bus.wr_data = d;
        bus.rd_en   = rd;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'd0);
        check({tag, "_empty"}, 32'(bus.empty), 32'd1);
        check({tag, "_aempty"}, 32'(bus.almost_empty), 32'd1);
        check({tag, "_full"}, 32'(bus.full), 32'd0);
        check({tag, "_afull"}, 32'(bus.almost_full), 32'd0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
        check({tag, "_udf"}, 32'(bus.underflow), 32'd0);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 32'd0);
    endtask

`ifndef SYNC_FIFO_FWFT_EN
    logic [7:0] model_q[$];
    logic [7:0] exp_b;
    int         k;
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.rd_en   = 1'b0;

`ifndef SYNC_FIFO_FWFT_EN
        // 1: write 0x00..0x0F then read them back in order.
        do_reset();
        check_reset_state("rst1");
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        check("t1_count16", 32'(bus.count), 32'd16);
        check("t1_not_empty", 32'(bus.empty), 32'd0);
        check("t1_aempty16", 32'(bus.almost_empty), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("t1_rd", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'(i)});
        end
        check("t1_count0", 32'(bus.count), 32'd0);
        check("t1_empty", 32'(bus.empty), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("t1_idle_valid", 32'(bus.rd_valid), 32'd0);
        check("t1_idle_hold", 32'(bus.rd_data), 32'h0F);

        // 2: fill to DEPTH, almost_full at 2040, overflow on extra write.
        do_reset();
        for (int i = 0; i < 2048; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 2038) check("t2_afull_2039", 32'(bus.almost_full), 32'd0);
            if (i == 2039) check("t2_afull_2040", 32'(bus.almost_full), 32'd1);
        end
        check("t2_full", 32'(bus.full), 32'd1);
        check("t2_count", 32'(bus.count), 32'd2048);
        check("t2_no_ovf", 32'(bus.overflow), 32'd0);
        step(1'b1, 8'hEE, 1'b0);
        check("t2_ovf", 32'(bus.overflow), 32'd1);
        check("t2_count_hold", 32'(bus.count), 32'd2048);
        check("t2_full_hold", 32'(bus.full), 32'd1);

        // 3: full with concurrent write+read -> only the read is accepted.
        step(1'b1, 8'h77, 1'b1);
        check("t3_count", 32'(bus.count), 32'd2047);
        check("t3_full", 32'(bus.full), 32'd0);
        check("t3_rd", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'h00});
        for (int i = 1; i < 2048; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("t3_drain", 32'(bus.rd_data), 32'(i[7:0]));
        end
        check("t3_empty", 32'(bus.empty), 32'd1);
        check("t3_ovf_sticky", 32'(bus.overflow), 32'd1);

        // 4: steady 100-word occupancy with simultaneous traffic across the wrap.
        do_reset();
        check("t4_ovf_cleared", 32'(bus.overflow), 32'd0);
        k = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(k), 1'b0);
            model_q.push_back(8'(k));
            k++;
        end
        for (int i = 0; i < 5000; i++) begin
            step(1'b1, 8'(k), 1'b1);
            model_q.push_back(8'(k));
            k++;
            exp_b = model_q.pop_front();
            check("t4_rd", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, exp_b});
        end
        check("t4_count", 32'(bus.count), 32'd100);

        // 5: underflow on empty read; almost_empty across 9 -> 8.
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        check("t5_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("t5_udf", 32'(bus.underflow), 32'd1);
        check("t5_count", 32'(bus.count), 32'd0);
        check("t5_empty", 32'(bus.empty), 32'd1);
        check("t5_rd_data", 32'(bus.rd_data), 32'd0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b0);
            if (i == 7) check("t5_aempty_8", 32'(bus.almost_empty), 32'd1);
        end
        check("t5_aempty_9", 32'(bus.almost_empty), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("t5_count8", 32'(bus.count), 32'd8);
        check("t5_aempty_back", 32'(bus.almost_empty), 32'd1);
        check("t5_rd_first", 32'(bus.rd_data), 32'h30);
        check("t5_udf_sticky", 32'(bus.underflow), 32'd1);
`else
        // 6: first-word-fall-through timing and ordering.
        do_reset();
        check_reset_state("rst6");
        step(1'b1, 8'hA5, 1'b0);
        check("t6_count1", 32'(bus.count), 32'd1);
        check("t6_empty_e0", 32'(bus.empty), 32'd1);
        check("t6_valid_e0", 32'(bus.rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("t6_valid_e1", 32'(bus.rd_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("t6_valid_e2", 32'(bus.rd_valid), 32'd1);
        check("t6_data_e2", 32'(bus.rd_data), 32'hA5);
        check("t6_empty_e2", 32'(bus.empty), 32'd0);
        check("t6_count_e2", 32'(bus.count), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("t6_empty_pop", 32'(bus.empty), 32'd1);
        check("t6_valid_pop", 32'(bus.rd_valid), 32'd0);
        check("t6_count_pop", 32'(bus.count), 32'd0);
        check("t6_no_udf", 32'(bus.underflow), 32'd0);
        step(1'b0, 8'h00, 1'b1);
        check("t6_udf", 32'(bus.underflow), 32'd1);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check("t6_head0", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'h11});
        check("t6_count3", 32'(bus.count), 32'd3);
        step(1'b0, 8'h00, 1'b1);
        check("t6_head1", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'h22});
        step(1'b0, 8'h00, 1'b1);
        check("t6_head2", {23'd0, bus.rd_valid, bus.rd_data}, {23'd0, 1'b1, 8'h33});
        step(1'b0, 8'h00, 1'b1);
        check("t6_drained", 32'(bus.empty), 32'd1);
        check("t6_count_end", 32'(bus.count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
